// File: rtl/cdctl_led_pkg.sv
// Shared definitions for the multi-channel status-indicator driver.
//   mode_t / MODE_* : channel mode encoding carried on wr_mode
//   calc_div        : gclk cycles per timebase tick
package cdctl_led_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_OFF   = 3'd0;
  localparam mode_t MODE_ON    = 3'd1;
  localparam mode_t MODE_BLINK = 3'd2;
  localparam mode_t MODE_BURST = 3'd3;
  localparam mode_t MODE_PWM   = 3'd4;

  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/cdctl_led_chan.sv
// One indicator channel: mode register, phase counter, burst counter and lit flag.
// Optional feature macro: LED_CTRL_PWM_EN (adds pwm_cnt input and PWM mode).
// Ports:
//   gclk, rst          clock, synchronous active-high reset
//   tick               shared timebase tick
//   wr                 write pulse for this channel
//   wr_mode/period/cnt configuration captured on wr
//   pwm_cnt            shared free-running PWM counter (PWM builds only)
//   lit                current lit state (registered)
//   busy               channel is in an active burst
//   done               one-cycle pulse when a burst completes
module cdctl_led_chan
  import cdctl_led_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                gclk,
  input  logic                rst,
  input  logic                tick,
  input  logic                wr,
  input  mode_t               wr_mode,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [PERIOD_W-1:0] wr_count,
`ifdef LED_CTRL_PWM_EN
  input  logic [7:0]          pwm_cnt,
`endif
  output logic                lit,
  output logic                busy,
  output logic                done
);

  mode_t               mode_q, mode_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] phase_q, phase_d;
  logic [PERIOD_W-1:0] rem_q, rem_d;
  logic                lit_q, lit_d;
  logic                done_q, done_d;
  logic [PERIOD_W-1:0] per_m1;

  // A period of 0 behaves like 1: toggle on every tick.
  assign per_m1 = (per_q == '0) ? '0 : per_q - PERIOD_W'(1);

  always_comb begin
    mode_d  = mode_q;
    per_d   = per_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    lit_d   = lit_q;
    done_d  = 1'b0;
    if (wr) begin
      // A write overrides any completion or tick in the same cycle.
      phase_d = '0;
      per_d   = wr_period;
      rem_d   = wr_count;
      case (wr_mode)
        MODE_ON, MODE_BLINK: begin
          mode_d = wr_mode;
          lit_d  = 1'b1;
        end
        MODE_BURST: begin
          if (wr_count == '0) begin
            mode_d = MODE_OFF;
            lit_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            mode_d = MODE_BURST;
            lit_d  = 1'b1;
          end
        end
`ifdef LED_CTRL_PWM_EN
        MODE_PWM: begin
          mode_d = MODE_PWM;
          lit_d  = pwm_cnt < wr_period[7:0];
        end
`endif
        default: begin
          mode_d = MODE_OFF;
          lit_d  = 1'b0;
        end
      endcase
    end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
      if (phase_q == per_m1) begin
        phase_d = '0;
        // A blink is counted when an unlit phase ends.
        if (mode_q == MODE_BURST && !lit_q) begin
          if (rem_q <= PERIOD_W'(1)) begin
            mode_d = MODE_OFF;
            done_d = 1'b1;
          end else begin
            rem_d = rem_q - PERIOD_W'(1);
            lit_d = 1'b1;
          end
        end else begin
          lit_d = ~lit_q;
        end
      end else begin
        phase_d = phase_q + PERIOD_W'(1);
      end
    end
`ifdef LED_CTRL_PWM_EN
    else if (mode_q == MODE_PWM) begin
      lit_d = pwm_cnt < per_q[7:0];
    end
`endif
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      mode_q  <= MODE_OFF;
      per_q   <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      lit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      per_q   <= per_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      lit_q   <= lit_d;
      done_q  <= done_d;
    end
  end

  assign lit  = lit_q;
  assign busy = (mode_q == MODE_BURST);
  assign done = done_q;

endmodule

// File: rtl/cdctl_led_ctrl.sv
// Multi-channel status-indicator driver (off / on / blink / counted burst).
// Optional feature macro: LED_CTRL_PWM_EN (mode 4 = PWM brightness from a free-running
// 8-bit gclk counter; otherwise mode 4 behaves as OFF).
// Ports:
//   gclk, rst                      clock, synchronous active-high reset
//   wr_en, wr_ch, wr_mode,
//   wr_period, wr_count            single-cycle channel programming strobe and fields
//   force_on                       forces every output lit
//   led                            registered indicator outputs (ACTIVE_LOW inverts)
//   busy                           channel is in an active burst
//   done                           one-cycle burst-complete pulse
module cdctl_led_ctrl
  import cdctl_led_pkg::*;
#(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned PERIOD_W   = 16,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                gclk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [3:0]          wr_ch,
  input  logic [2:0]          wr_mode,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [PERIOD_W-1:0] wr_count,
  input  logic                force_on,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam int unsigned DIV  = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PS_W = $clog2(DIV);

  logic [PS_W-1:0]     ps_q;
  logic                tick;
  logic [CHANNELS-1:0] lit;
  logic [CHANNELS-1:0] led_q;

  assign tick = (ps_q == PS_W'(DIV - 1));

  always_ff @(posedge gclk) begin
    if (rst || tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + PS_W'(1);
    end
  end

`ifdef LED_CTRL_PWM_EN
  logic [7:0] pwm_q;

  always_ff @(posedge gclk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 8'd1;
    end
  end
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic chan_wr;
    // Channel numbers at or above CHANNELS match no instance and are dropped.
    assign chan_wr = wr_en && (wr_ch == 4'(i));

    cdctl_led_chan #(
      .PERIOD_W(PERIOD_W)
    ) u_chan (
      .gclk      (gclk),
      .rst       (rst),
      .tick      (tick),
      .wr        (chan_wr),
      .wr_mode   (wr_mode),
      .wr_period (wr_period),
      .wr_count  (wr_count),
`ifdef LED_CTRL_PWM_EN
      .pwm_cnt   (pwm_q),
`endif
      .lit       (lit[i]),
      .busy      (busy[i]),
      .done      (done[i])
    );
  end

  // force_on only masks the outputs; channel state keeps running underneath.
  always_ff @(posedge gclk) begin
    if (rst) begin
      led_q <= {CHANNELS{ACTIVE_LOW}};
    end else begin
      led_q <= ({CHANNELS{force_on}} | lit) ^ {CHANNELS{ACTIVE_LOW}};
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_cdctl_led_ctrl.sv
module tb_cdctl_led_ctrl;

  localparam int CH  = 4;
  localparam int DIV = 10;
  localparam int PW  = 16;

  localparam int M_OFF   = 0;
  localparam int M_ON    = 1;
  localparam int M_BLINK = 2;
  localparam int M_BURST = 3;

  logic          gclk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_ch = '0;
  logic [2:0]    wr_mode = '0;
  logic [PW-1:0] wr_period = '0;
  logic [PW-1:0] wr_count = '0;
  logic          force_on = 1'b0;
  logic [CH-1:0] led, busy, done;
  logic [CH-1:0] led_n, busy_n, done_n;

  always #5 gclk = ~gclk;

  cdctl_led_ctrl #(
    .CHANNELS(CH), .CLK_HZ(1000), .TICK_HZ(100), .PERIOD_W(PW), .ACTIVE_LOW(1'b0)
  ) dut (
    .gclk(gclk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .wr_count(wr_count), .force_on(force_on),
    .led(led), .busy(busy), .done(done)
  );

  cdctl_led_ctrl #(
    .CHANNELS(CH), .CLK_HZ(1000), .TICK_HZ(100), .PERIOD_W(PW), .ACTIVE_LOW(1'b1)
  ) dut_n (
    .gclk(gclk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_period(wr_period), .wr_count(wr_count), .force_on(force_on),
    .led(led_n), .busy(busy_n), .done(done_n)
  );

  // Reference model: each channel remembers how many ticks elapsed since its write;
  // the lit state is the parity of completed half-periods.
  int            m_mode[CH];
  int            m_p[CH];
  int            m_cnt[CH];
  int            m_k[CH];
  logic [CH-1:0] m_lit, m_busy, m_done, m_led;
  int            cyc;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    logic tick;
    int   md;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = M_OFF; m_p[i] = 1; m_cnt[i] = 0; m_k[i] = 0;
      end
      m_lit = '0; m_busy = '0; m_done = '0; m_led = '0;
      cyc = 0;
    end else begin
      tick  = (cyc % DIV) == DIV - 1;
      m_led = {CH{force_on}} | m_lit;
      m_done = '0;
      for (int i = 0; i < CH; i++) begin
        if (wr_en && int'(wr_ch) == i) begin
          md = (int'(wr_mode) > 3) ? M_OFF : int'(wr_mode);
          m_p[i]   = (wr_period == 0) ? 1 : int'(wr_period);
          m_cnt[i] = int'(wr_count);
          m_k[i]   = 0;
          if (md == M_BURST && m_cnt[i] == 0) begin
            md = M_OFF;
            m_done[i] = 1'b1;
          end
          m_mode[i] = md;
        end else if (tick && (m_mode[i] == M_BLINK || m_mode[i] == M_BURST)) begin
          m_k[i]++;
          if (m_mode[i] == M_BURST && m_k[i] / m_p[i] >= 2 * m_cnt[i]) begin
            m_mode[i] = M_OFF;
            m_done[i] = 1'b1;
          end
        end
        m_lit[i] = (m_mode[i] == M_ON) ||
                   ((m_mode[i] == M_BLINK || m_mode[i] == M_BURST) && ((m_k[i] / m_p[i]) % 2 == 0));
        m_busy[i] = (m_mode[i] == M_BURST);
      end
      cyc++;
    end
  endtask

  task automatic step();
    @(posedge gclk);
    model_edge();
    #1;
    chk("cycle", {20'd0, led, busy, done}, {20'd0, m_led, m_busy, m_done});
    chk("cycle_inv", {20'd0, led_n, busy_n, done_n}, {20'd0, ~m_led, m_busy, m_done});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic write(input int ch, input int mode, input int per, input int cnt);
    wr_en = 1'b1; wr_ch = 4'(ch); wr_mode = 3'(mode);
    wr_period = PW'(per); wr_count = PW'(cnt);
    step();
    wr_en = 1'b0;
  endtask

  typedef struct {
    int         ch;
    int         mode;
    int         period;
    int         count;
    int         n;
    logic [3:0] e_led;
    logic [3:0] e_busy;
    logic [3:0] e_done;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // Each vector: reset, write during the first tick cycle, wait n edges, check.
    vecs.push_back('{0, M_ON,    0, 0,  0, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{0, M_ON,    0, 0,  1, 4'h1, 4'h0, 4'h0});
    vecs.push_back('{1, M_BLINK, 3, 0, 25, 4'h2, 4'h0, 4'h0});
    vecs.push_back('{1, M_BLINK, 3, 0, 41, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, M_BLINK, 0, 0, 12, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, M_BLINK, 0, 0, 22, 4'h2, 4'h0, 4'h0});
    vecs.push_back('{2, M_BURST, 1, 2,  0, 4'h0, 4'h4, 4'h0});
    vecs.push_back('{2, M_BURST, 1, 2,  5, 4'h4, 4'h4, 4'h0});
    vecs.push_back('{2, M_BURST, 1, 2, 25, 4'h4, 4'h4, 4'h0});
    vecs.push_back('{2, M_BURST, 1, 2, 40, 4'h0, 4'h0, 4'h4});
    vecs.push_back('{2, M_BURST, 1, 2, 41, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{3, M_BURST, 1, 0,  0, 4'h0, 4'h0, 4'h8});
    vecs.push_back('{3, M_BURST, 1, 0,  1, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{0, 5,       0, 0,  3, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{5, M_ON,    0, 0,  3, 4'h0, 4'h0, 4'h0});
    vecs.push_back('{1, 4,       0, 0,  3, 4'h0, 4'h0, 4'h0});

    // Reset state
    do_reset();
    chk("reset_led", {28'd0, led}, 32'h0);
    chk("reset_busy", {28'd0, busy}, 32'h0);
    chk("reset_done", {28'd0, done}, 32'h0);
    chk("reset_led_active_low", {28'd0, led_n}, 32'hF);

    foreach (vecs[i]) begin
      do_reset();
      repeat (9) step();
      write(vecs[i].ch, vecs[i].mode, vecs[i].period, vecs[i].count);
      repeat (vecs[i].n) step();
      chk($sformatf("vec%0d_led", i), {28'd0, led}, {28'd0, vecs[i].e_led});
      chk($sformatf("vec%0d_busy", i), {28'd0, busy}, {28'd0, vecs[i].e_busy});
      chk($sformatf("vec%0d_done", i), {28'd0, done}, {28'd0, vecs[i].e_done});
    end

    // Burst completion racing a write to the same channel
    do_reset();
    repeat (9) step();
    write(2, M_BURST, 1, 1);
    repeat (19) step();
    write(2, M_ON, 0, 0);
    chk("race_done", {28'd0, done}, 32'h0);
    chk("race_busy", {28'd0, busy}, 32'h0);
    step();
    chk("race_led", {28'd0, led}, 32'h4);
    repeat (5) step();
    // Reset in the middle of a burst
    write(3, M_BURST, 2, 3);
    repeat (15) step();
    do_reset();
    chk("abort_done", {28'd0, done}, 32'h0);
    chk("abort_busy", {28'd0, busy}, 32'h0);

    // force_on during BLINK, then release and stop
    do_reset();
    repeat (9) step();
    write(1, M_BLINK, 3, 0);
    repeat (37) step();
    force_on = 1'b1;
    step();
    chk("force_led", {28'd0, led}, 32'hF);
    repeat (20) step();
    write(5, M_ON, 0, 0);
    repeat (28) step();
    chk("force_hold_led", {28'd0, led}, 32'hF);
    force_on = 1'b0;
    repeat (40) step();
    write(1, M_OFF, 0, 0);
    step();
    chk("off_led1", {31'd0, led[1]}, 32'h0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) force_on = ~force_on;
      if ($urandom_range(0, 11) == 0) begin
        write(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else begin
        step();
      end
    end
    force_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
